// File: rtl/divisao_num_matriz_if.sv
//------------------------------------------------------------------------------
// divisao_num_matriz_if : start/busy/done bus of the matrix-by-scalar divider
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface divisao_num_matriz_if;
  logic         start;
  logic [199:0] matriz_A;
  logic [7:0]   num_inteiro;
  logic [1:0]   matrix_size;
  logic [199:0] nova_matriz_A;
  logic         overflow_flag;
  logic         div_zero_flag;
  logic         busy;
  logic         done;

  modport master (
    output start, matriz_A, num_inteiro, matrix_size,
    input  nova_matriz_A, overflow_flag, div_zero_flag, busy, done
  );

  modport slave (
    input  start, matriz_A, num_inteiro, matrix_size,
    output nova_matriz_A, overflow_flag, div_zero_flag, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/divisao_num_matriz.sv
//------------------------------------------------------------------------------
// divisao_num_matriz : sequential matrix / scalar signed divider, one element
// at a time through an 8-step restoring divider.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divisao_num_matriz (
  input  logic                        clk,
  input  logic                        rst_n,
  divisao_num_matriz_if.slave         bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   state_q, state_d;
  logic [199:0] a_q;
  logic [7:0]   b_q;
  logic [1:0]   size_q;
  logic [4:0]   idx_q;
  logic [7:0]   dvd_q;      // dividend bits shift out, quotient bits shift in
  logic [7:0]   rem_q;
  logic [7:0]   divm_q;
  logic         neg_q;
  logic [2:0]   iter_q;
  logic [199:0] res_q;
  logic         ovf_acc_q;
  logic [199:0] nova_q;
  logic         ovf_q;
  logic         dz_q;
  logic         busy_q;
  logic         done_q;

  logic [7:0]   w_elem;
  logic [7:0]   w_amag;
  logic [7:0]   w_bmag;
  logic [8:0]   w_shift;
  logic [8:0]   w_diff;
  logic [7:0]   w_qsgn;
  logic         w_ovf;
  logic [4:0]   w_count;
  logic         w_last;
  logic [199:0] w_res_wr;

  assign w_elem  = a_q[{idx_q, 3'b000} +: 8];
  assign w_amag  = w_elem[7] ? (8'd0 - w_elem) : w_elem;
  assign w_bmag  = b_q[7] ? (8'd0 - b_q) : b_q;
  assign w_shift = {rem_q, dvd_q[7]};
  // Bit 8 set means the trial subtraction borrowed, i.e. restore.
  assign w_diff  = w_shift - {1'b0, divm_q};
  assign w_qsgn  = neg_q ? (8'd0 - dvd_q) : dvd_q;
  assign w_ovf   = !neg_q && (dvd_q == 8'h80);
  assign w_last  = ((idx_q + 5'd1) == w_count);

  always_comb begin
    w_count = 5'd4;
    case (size_q)
      2'b00:   w_count = 5'd4;
      2'b01:   w_count = 5'd9;
      2'b10:   w_count = 5'd16;
      default: w_count = 5'd25;
    endcase
  end

  always_comb begin
    w_res_wr = res_q;
    w_res_wr[{idx_q, 3'b000} +: 8] = w_qsgn;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.num_inteiro == 8'd0) ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_DIV;
      S_DIV:   if (iter_q == 3'd7) state_d = S_WRITE;
      S_WRITE: state_d = w_last ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      size_q    <= '0;
      idx_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      divm_q    <= '0;
      neg_q     <= 1'b0;
      iter_q    <= '0;
      res_q     <= '0;
      ovf_acc_q <= 1'b0;
      nova_q    <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q       <= bus.matriz_A;
            b_q       <= bus.num_inteiro;
            size_q    <= bus.matrix_size;
            idx_q     <= '0;
            res_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            // Zero divisor skips the datapath and publishes straight away.
            if (bus.num_inteiro == 8'd0) begin
              nova_q <= '0;
              ovf_q  <= 1'b0;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          dvd_q  <= w_amag;
          divm_q <= w_bmag;
          neg_q  <= w_elem[7] ^ b_q[7];
          rem_q  <= '0;
          iter_q <= '0;
        end
        S_DIV: begin
          dvd_q  <= {dvd_q[6:0], !w_diff[8]};
          rem_q  <= w_diff[8] ? w_shift[7:0] : w_diff[7:0];
          iter_q <= iter_q + 3'd1;
        end
        S_WRITE: begin
          res_q     <= w_res_wr;
          ovf_acc_q <= ovf_acc_q | w_ovf;
          idx_q     <= idx_q + 5'd1;
          if (w_last) begin
            nova_q <= w_res_wr;
            ovf_q  <= ovf_acc_q | w_ovf;
            dz_q   <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.nova_matriz_A = nova_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.div_zero_flag = dz_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_divisao_num_matriz.sv
//------------------------------------------------------------------------------
// tb_divisao_num_matriz : directed scoreboard bench for divisao_num_matriz
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_divisao_num_matriz;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divisao_num_matriz_if bus ();

  divisao_num_matriz dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [199:0] res;
    logic         ovf;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int n_elem(input logic [1:0] s);
    case (s)
      2'b00:   return 4;
      2'b01:   return 9;
      2'b10:   return 16;
      default: return 25;
    endcase
  endfunction

  function automatic logic [199:0] fill(input logic [7:0] v, input int n);
    logic [199:0] r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  // Reference quotient: truncating signed division on plain integers.
  function automatic logic [199:0] ref_div(input logic [199:0] a, input logic [7:0] b, input int n);
    logic [199:0] r = '0;
    int x, y, q;
    y = $signed(b);
    for (int i = 0; i < n; i++) begin
      x = $signed(a[i*8 +: 8]);
      q = x / y;
      r[i*8 +: 8] = q[7:0];
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      chk("done_expected", 200'(sb.size() != 0), 200'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("result",   bus.nova_matriz_A, mon_e.res);
        chk("ovf_flag", 200'(bus.overflow_flag), 200'(mon_e.ovf));
        chk("dz_flag",  200'(bus.div_zero_flag), 200'(mon_e.dz));
        chk("latency",  200'(cyc - mon_e.t0 + 1), 200'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [199:0] a, input logic [7:0] b, input logic [1:0] s,
                       input logic [199:0] res, input logic ovf, input logic dz, input int hold);
    exp_t e;
    @(negedge clk);
    bus.matriz_A    = a;
    bus.num_inteiro = b;
    bus.matrix_size = s;
    bus.start       = 1'b1;
    e.res = res;
    e.ovf = ovf;
    e.dz  = dz;
    e.t0  = cyc + 1;
    e.lat = (b == 8'd0) ? 1 : 10 * n_elem(s) + 1;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    bus.start       = 1'b0;
    bus.matriz_A    = ~a;
    bus.num_inteiro = b ^ 8'h5A;
    bus.matrix_size = ~s;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("idle_timeout", 200'(k < 600), 200'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [199:0] a5, e5, a4, e4;
    bus.start       = 1'b0;
    bus.matriz_A    = '0;
    bus.num_inteiro = '0;
    bus.matrix_size = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus.nova_matriz_A, '0);
    chk("rst_flags",  200'({bus.overflow_flag, bus.div_zero_flag, bus.busy, bus.done}), '0);
    rst_n = 1'b1;

    // 2x2 {10,-7,0,127}/3 -> {3,-2,0,42}
    issue(200'h7F00F90A, 8'd3, 2'b00, 200'h2A00FE03, 1'b0, 1'b0, 1);
    chk("busy_running", 200'(bus.busy), 200'd1);
    chk("done_low_running", 200'(bus.done), 200'd0);
    wait_idle();

    // -128 / -1 overflows, -128 / 1 does not
    issue(fill(8'h80, 25), 8'hFF, 2'b01, fill(8'h80, 9), 1'b1, 1'b0, 1);
    wait_idle();
    issue(fill(8'h80, 25), 8'h01, 2'b01, fill(8'h80, 9), 1'b0, 1'b0, 1);
    wait_idle();

    // Divide by zero; start held into DONE must not launch a second job
    issue(fill(8'h33, 25), 8'h00, 2'b11, '0, 1'b0, 1'b1, 2);
    wait_idle();
    issue(200'h0109FC04, 8'd2, 2'b00, 200'h0004FE02, 1'b0, 1'b0, 1);
    wait_idle();

    // 5x5 element i = i-12 divided by -5
    a5 = '0;
    e5 = '0;
    for (int i = 0; i < 25; i++) a5[i*8 +: 8] = 8'(i - 12);
    for (int i = 0; i < 25; i++) e5[i*8 +: 8] = 8'((i - 12) / (-5));
    chk("e5_el0",  200'(e5[7:0]),     200'h02);
    chk("e5_el24", 200'(e5[199:192]), 200'hFE);
    issue(a5, 8'hFB, 2'b11, e5, 1'b0, 1'b0, 1);
    wait_idle();

    // 2x2 on a full bus of 127: inactive bytes stay zero
    issue(fill(8'h7F, 25), 8'd1, 2'b00, fill(8'h7F, 4), 1'b0, 1'b0, 1);
    wait_idle();

    // 4x4 with a stray start mid-operation
    a4 = '0;
    for (int i = 0; i < 25; i++) a4[i*8 +: 8] = 8'(i * 13 - 100);
    e4 = ref_div(a4, 8'd7, 16);
    issue(a4, 8'd7, 2'b10, e4, 1'b0, 1'b0, 1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Abort a job with reset
    issue(a5, 8'd3, 2'b01, ref_div(a5, 8'd3, 9), 1'b0, 1'b0, 1);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", bus.nova_matriz_A, '0);
    chk("abort_flags",  200'({bus.overflow_flag, bus.div_zero_flag, bus.busy, bus.done}), '0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("abort_hold", 200'({bus.busy, bus.done}), '0);
    rst_n = 1'b1;

    issue(200'h7F00F90A, 8'd3, 2'b00, 200'h2A00FE03, 1'b0, 1'b0, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 200'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
